// File: rtl/l2_mover_pkg.sv
// Shared types and geometry for the L2 line mover: line/beat widths, command opcodes and FSM states.
package l2_mover_pkg;

    localparam int unsigned S_OFFSET   = 5;
    localparam int unsigned S_INDEX    = 3;
    localparam int unsigned BEAT_W     = 64;
    localparam int unsigned LINE_W     = 8 * (2 ** S_OFFSET);
    localparam int unsigned BEATS      = LINE_W / BEAT_W;
    localparam int unsigned BEAT_BYTES = BEAT_W / 8;
    localparam int unsigned WE_W       = 2 ** S_OFFSET;
    localparam int unsigned K_W        = $clog2(BEATS);
    localparam int unsigned CNT_W      = 16;

    localparam logic [K_W-1:0] K_LAST = K_W'(BEATS - 1);

    typedef enum logic {
        OP_FILL  = 1'b0,
        OP_EVICT = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_EV_RD,
        ST_EV_CAP,
        ST_EV_TX,
        ST_DONE
    } state_t;

    // Byte write-enables covering the bytes of beat k within the line.
    function automatic logic [WE_W-1:0] beat_mask(input logic [K_W-1:0] k);
        logic [WE_W-1:0] base;
        base = {{(WE_W - BEAT_BYTES){1'b0}}, {BEAT_BYTES{1'b1}}};
        return base << (BEAT_BYTES * 32'(k));
    endfunction

endpackage

// File: rtl/l2_evict_shift_reg.sv
// Evict line buffer: captures one array line and presents the beat selected by the beat counter.
module l2_evict_shift_reg
    import l2_mover_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] line_in,
    input  logic [K_W-1:0]    sel,
    output logic [BEAT_W-1:0] beat_out
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = line_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign beat_out = line_q[BEAT_W * 32'(sel) +: BEAT_W];

endmodule

// File: rtl/l2_line_mover.sv
// L2 line mover: FILL writes 4 bus beats into one set via byte enables; EVICT reads a set and streams 4 beats.
// Define L2_LINE_MOVER_STATS_EN to enable the saturating fill/evict completion counters.
module l2_line_mover
    import l2_mover_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [S_INDEX-1:0] cmd_index,
    output logic               done,
    input  logic [BEAT_W-1:0]  mem_rdata,
    input  logic               mem_rvalid,
    output logic [BEAT_W-1:0]  mem_wdata,
    output logic               mem_wvalid,
    input  logic               mem_wready,
    output logic               arr_read,
    output logic [S_INDEX-1:0] arr_rindex,
    output logic [S_INDEX-1:0] arr_windex,
    output logic [WE_W-1:0]    arr_write_en,
    output logic [LINE_W-1:0]  arr_datain,
    input  logic [LINE_W-1:0]  arr_dataout,
    output logic [CNT_W-1:0]   fill_cnt,
    output logic [CNT_W-1:0]   evict_cnt
);

    state_t             state_q, state_d;
    logic [S_INDEX-1:0] idx_q, idx_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               buf_load;
    logic [BEAT_W-1:0]  buf_beat;
    logic               accept;

    // cmd_ready stays low while rst is held even though the state already reads IDLE.
    assign accept = (state_q == ST_IDLE) && cmd_valid && !rst;

    l2_evict_shift_reg u_evict_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .line_in  (arr_dataout),
        .sel      (k_q),
        .beat_out (buf_beat)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        k_d          = k_q;
        cmd_ready    = 1'b0;
        done         = 1'b0;
        arr_read     = 1'b0;
        arr_write_en = '0;
        arr_datain   = '0;
        mem_wvalid   = 1'b0;
        mem_wdata    = '0;
        buf_load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (accept) begin
                    idx_d   = cmd_index;
                    k_d     = '0;
                    state_d = (op_t'(cmd_op) == OP_EVICT) ? ST_EV_RD : ST_FILL;
                end
            end
            ST_FILL: begin
                // Write goes out in the same cycle as the beat; there is no backpressure on fills.
                if (mem_rvalid) begin
                    arr_write_en = beat_mask(k_q);
                    arr_datain   = {BEATS{mem_rdata}};
                    k_d          = k_q + K_W'(1);
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EV_RD: begin
                arr_read = 1'b1;
                state_d  = ST_EV_CAP;
            end
            ST_EV_CAP: begin
                buf_load = 1'b1;
                state_d  = ST_EV_TX;
            end
            ST_EV_TX: begin
                mem_wvalid = 1'b1;
                mem_wdata  = buf_beat;
                if (mem_wready) begin
                    k_d = k_q + K_W'(1);
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
        end
    end

    assign arr_rindex = idx_q;
    assign arr_windex = idx_q;

`ifdef L2_LINE_MOVER_STATS_EN
    op_t              op_q, op_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0] evict_cnt_q, evict_cnt_d;

    // Completion counters saturate rather than wrap.
    always_comb begin
        op_d        = op_q;
        fill_cnt_d  = fill_cnt_q;
        evict_cnt_d = evict_cnt_q;
        if (accept) begin
            op_d = op_t'(cmd_op);
        end
        if (state_q == ST_DONE) begin
            if ((op_q == OP_FILL) && (fill_cnt_q != '1)) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
            if ((op_q == OP_EVICT) && (evict_cnt_q != '1)) begin
                evict_cnt_d = evict_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OP_FILL;
            fill_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else begin
            op_q        <= op_d;
            fill_cnt_q  <= fill_cnt_d;
            evict_cnt_q <= evict_cnt_d;
        end
    end

    assign fill_cnt  = fill_cnt_q;
    assign evict_cnt = evict_cnt_q;
`else
    assign fill_cnt  = '0;
    assign evict_cnt = '0;
`endif

endmodule

// File: tb/tb_l2_line_mover.sv
// Randomized self-checking bench for l2_line_mover: array behavioural model plus expected-line reference.
module tb_l2_line_mover;
    import l2_mover_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_op = 1'b0;
    logic [2:0]         cmd_index = '0;
    logic               done;
    logic [63:0]        mem_rdata = '0;
    logic               mem_rvalid = 1'b0;
    logic [63:0]        mem_wdata;
    logic               mem_wvalid;
    logic               mem_wready = 1'b0;
    logic               arr_read;
    logic [2:0]         arr_rindex;
    logic [2:0]         arr_windex;
    logic [31:0]        arr_write_en;
    logic [255:0]       arr_datain;
    logic [255:0]       arr_dataout;
    logic [15:0]        fill_cnt;
    logic [15:0]        evict_cnt;

    int errors = 0;
    int checks = 0;
    int n_fill = 0;
    int n_evict = 0;
    logic [255:0] arr_mem [8];
    logic [255:0] exp_mem [8];
    logic [7:0]   filled = '0;

    l2_line_mover dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .done(done), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .arr_read(arr_read), .arr_rindex(arr_rindex), .arr_windex(arr_windex),
        .arr_write_en(arr_write_en), .arr_datain(arr_datain), .arr_dataout(arr_dataout),
        .fill_cnt(fill_cnt), .evict_cnt(evict_cnt)
    );

    always #5 clk = ~clk;

    // Byte-masked array with one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < 32; b++) begin
            if (arr_write_en[b]) arr_mem[arr_windex][8*b +: 8] <= arr_datain[8*b +: 8];
        end
        if (arr_read) arr_dataout <= arr_mem[arr_rindex];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [2:0] idx, input logic [255:0] line, input logic [15:0] vpat);
        int k;
        int cyc;
        logic v;
        logic [63:0] beat;
        k = 0;
        cyc = 0;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_index = idx;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fill_accept cmd_ready=%b exp=1", cmd_ready); end
        tick();
        while (k < 4 && cyc < 40) begin
            v = (cyc < 16) ? vpat[cyc] : 1'b1;
            beat = line[64*k +: 64];
            mem_rvalid = v;
            mem_rdata = v ? beat : {$urandom, $urandom};
            cmd_valid = 1'($urandom);
            cmd_index = 3'($urandom);
            #1;
            checks++;
            if (v) begin
                if (arr_write_en !== (32'hFF << (8*k)) || arr_windex !== idx || arr_datain !== {4{beat}}
                    || cmd_ready !== 1'b0 || done !== 1'b0 || arr_read !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_beat k=%0d we=%h exp=%h widx=%0d exp=%0d rdy=%b done=%b", k,
                             arr_write_en, 32'hFF << (8*k), arr_windex, idx, cmd_ready, done);
                end
                exp_mem[idx][64*k +: 64] = beat;
                k++;
            end else begin
                if (arr_write_en !== '0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_gap we=%h exp=0 rdy=%b done=%b", arr_write_en, cmd_ready, done);
                end
            end
            tick();
            cyc++;
        end
        mem_rvalid = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++;
        if (k != 4 || done !== 1'b1 || arr_write_en !== '0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_done beats=%0d exp=4 done=%b exp=1 we=%h rdy=%b", k, done, arr_write_en, cmd_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL fill_idle done=%b exp=0 rdy=%b exp=1", done, cmd_ready);
        end
        n_fill++;
        filled[idx] = 1'b1;
    endtask

    task automatic do_evict(input logic [2:0] idx, input logic [15:0] rpat);
        int k;
        int cyc;
        logic r;
        k = 0;
        cyc = 0;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_index = idx;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL evict_accept cmd_ready=%b exp=1", cmd_ready); end
        tick();
        cmd_valid = 1'b1; cmd_index = 3'($urandom); mem_rvalid = 1'b1; mem_wready = 1'b1;
        #1;
        checks++;
        if (arr_read !== 1'b1 || arr_rindex !== idx || mem_wvalid !== 1'b0 || arr_write_en !== '0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL evict_rd rd=%b exp=1 ridx=%0d exp=%0d wv=%b we=%h", arr_read, arr_rindex, idx, mem_wvalid, arr_write_en);
        end
        tick();
        checks++;
        if (arr_read !== 1'b0 || mem_wvalid !== 1'b0 || arr_write_en !== '0) begin
            errors++; $display("FAIL evict_cap rd=%b exp=0 wv=%b exp=0", arr_read, mem_wvalid);
        end
        tick();
        while (k < 4 && cyc < 60) begin
            r = (cyc < 16) ? rpat[cyc] : 1'b1;
            mem_wready = r;
            mem_rvalid = 1'($urandom);
            cmd_valid = 1'($urandom);
            #1;
            checks++;
            if (mem_wvalid !== 1'b1 || mem_wdata !== exp_mem[idx][64*k +: 64] || arr_read !== 1'b0
                || arr_write_en !== '0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL evict_beat k=%0d wv=%b wdata=%h exp=%h we=%h", k, mem_wvalid, mem_wdata,
                         exp_mem[idx][64*k +: 64], arr_write_en);
            end
            if (r) k++;
            tick();
            cyc++;
        end
        mem_wready = 1'b0; mem_rvalid = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++;
        if (k != 4 || done !== 1'b1 || mem_wvalid !== 1'b0) begin
            errors++; $display("FAIL evict_done beats=%0d exp=4 done=%b exp=1 wv=%b", k, done, mem_wvalid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL evict_idle done=%b exp=0 rdy=%b exp=1", done, cmd_ready);
        end
        n_evict++;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1; mem_rvalid = 1'b1; mem_wready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || done !== 1'b0 || arr_write_en !== '0 || arr_read !== 1'b0
            || mem_wvalid !== 1'b0 || fill_cnt !== '0 || evict_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b done=%b we=%h rd=%b wv=%b fc=%0d ec=%0d exp=all0",
                     cmd_ready, done, arr_write_en, arr_read, mem_wvalid, fill_cnt, evict_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || arr_write_en !== '0) begin
            errors++; $display("FAIL reset_release rdy=%b exp=1 we=%h exp=0", cmd_ready, arr_write_en);
        end
        tick();
    endtask

    task automatic test_fill_basic();
        do_fill(3'd5, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 16'hFFFF);
    endtask

    task automatic test_evict_basic();
        do_fill(3'd2, {64'hDDDD_0003_CAFE_F00D, 64'hCCCC_0002_1234_5678, 64'hBBBB_0001_8765_4321, 64'hAAAA_0000_DEAD_BEEF}, 16'hFFFF);
        do_evict(3'd2, 16'hFFFF);
    endtask

    task automatic test_evict_stall();
        do_evict(3'd5, 16'hFFC1);
    endtask

    task automatic test_fill_gaps();
        do_fill(3'd1, {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}}, 16'h0059);
        do_evict(3'd1, 16'($urandom));
    endtask

    task automatic test_reset_mid_fill();
        logic [63:0] b0;
        logic [63:0] b1;
        b0 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_index = 3'd6;
        tick();
        cmd_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = b0;
        tick();
        mem_rdata = b1;
        tick();
        exp_mem[6][63:0] = b0;
        exp_mem[6][127:64] = b1;
        mem_rdata = {$urandom, $urandom};
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (arr_write_en !== '0 || cmd_ready !== 1'b0 || done !== 1'b0 || arr_read !== 1'b0 || fill_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid we=%h rdy=%b done=%b fc=%0d exp=all0", arr_write_en, cmd_ready, done, fill_cnt);
        end
        n_fill = 0;
        n_evict = 0;
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_mid_done done=%b exp=0", done); end
        mem_rvalid = 1'b0;
        rst = 1'b0;
        tick();
        do_fill(3'd6, {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}}, 16'hFFFF);
        do_evict(3'd6, 16'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [2:0] idx;
        for (int i = 0; i < 12; i++) begin
            idx = 3'($urandom);
            if (($urandom_range(0, 1) == 0) || (filled[idx] == 1'b0)) begin
                do_fill(idx, {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}},
                        16'($urandom));
            end else begin
                do_evict(idx, 16'($urandom));
            end
        end
    endtask

    task automatic test_stats();
`ifdef L2_LINE_MOVER_STATS_EN
        checks++;
        if (fill_cnt !== 16'(n_fill) || evict_cnt !== 16'(n_evict)) begin
            errors++; $display("FAIL stats_count fc=%0d exp=%0d ec=%0d exp=%0d", fill_cnt, n_fill, evict_cnt, n_evict);
        end
        force dut.fill_cnt_q = 16'hFFFF;
        tick();
        release dut.fill_cnt_q;
        do_fill(3'd0, {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}}, 16'hFFFF);
        checks++;
        if (fill_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate fc=%h exp=ffff", fill_cnt); end
`else
        checks++;
        if (fill_cnt !== '0 || evict_cnt !== '0) begin
            errors++; $display("FAIL stats_disabled fc=%0d ec=%0d exp=0", fill_cnt, evict_cnt);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_basic();
        test_evict_basic();
        test_evict_stall();
        test_fill_gaps();
        test_reset_mid_fill();
        test_back_to_back();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
